// File: rtl/gecko_writeback_arbiter.sv
// gecko_writeback_arbiter
//   Owns the single register-file write port. After reset it zero-fills every
//   register address in order, then arbitrates round-robin among NUM_SOURCES
//   writeback producers, driving one registered write per cycle.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   src_valid  per-producer request valid             [NUM_SOURCES-1:0]
//   src_ready  per-producer grant (combinational)     [NUM_SOURCES-1:0]
//   src_addr   packed rd_addr, source i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   src_value  packed rd_value, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wb_valid   registered register-write strobe
//   wb_addr    registered register-write address
//   wb_value   registered register-write data
//   init_done  registered, high once the zero-fill sweep has completed
//
// Optional build macro:
//   GECKO_WRITEBACK_R0_FILTER_EN  granted requests to rd_addr 0 are accepted
//                                 but produce no write (sweep is unaffected)
module gecko_writeback_arbiter #(
  parameter int NUM_SOURCES = 3,
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SOURCES-1:0]            src_valid,
  output logic [NUM_SOURCES-1:0]            src_ready,
  input  logic [NUM_SOURCES*ADDR_WIDTH-1:0] src_addr,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_value,
  output logic                              wb_valid,
  output logic [ADDR_WIDTH-1:0]             wb_addr,
  output logic [DATA_WIDTH-1:0]             wb_value,
  output logic                              init_done
);

  localparam int PW = $clog2(NUM_SOURCES);

`ifdef GECKO_WRITEBACK_R0_FILTER_EN
  localparam bit R0_FILTER = 1'b1;
`else
  localparam bit R0_FILTER = 1'b0;
`endif

  localparam logic [0:0] SWEEP = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [PW-1:0]         rr_ptr;

  logic                  grant_found;
  logic [PW-1:0]         grant_idx;
  logic [PW-1:0]         next_ptr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_value;
  logic                  drop_r0;

  // Scan sources starting at rr_ptr; the index wraps explicitly at
  // NUM_SOURCES since NUM_SOURCES need not be a power of two.
  always_comb begin
    logic [PW:0] scan;
    scan        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan >= (PW+1)'(NUM_SOURCES))
        scan = scan - (PW+1)'(NUM_SOURCES);
      if (!grant_found && src_valid[scan[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_value = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      if (grant_idx == PW'(k)) begin
        sel_addr  = src_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_value = src_value[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    src_ready = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++)
      src_ready[k] = (state == RUN) && grant_found && (grant_idx == PW'(k));
  end

  assign next_ptr = (grant_idx == PW'(NUM_SOURCES-1)) ? '0 : grant_idx + 1'b1;
  assign drop_r0  = R0_FILTER && (sel_addr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SWEEP;
      sweep_cnt <= '0;
      rr_ptr    <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_value  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        SWEEP: begin
          wb_valid  <= 1'b1;
          wb_addr   <= sweep_cnt;
          wb_value  <= '0;
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          // In RUN a found grant is always a transfer: ready mirrors the grant.
          if (grant_found) begin
            rr_ptr <= next_ptr;
            if (drop_r0) begin
              wb_valid <= 1'b0;
            end else begin
              wb_valid <= 1'b1;
              wb_addr  <= sel_addr;
              wb_value <= sel_value;
            end
          end else begin
            wb_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gecko_writeback_arbiter.sv
module tb_gecko_writeback_arbiter;

  localparam int NS = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    src_valid;
  logic [NS-1:0]    src_ready;
  logic [NS*AW-1:0] src_addr;
  logic [NS*DW-1:0] src_value;
  logic             wb_valid;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_value;
  logic             init_done;

  int total = 0;
  int bad   = 0;

  gecko_writeback_arbiter #(
    .NUM_SOURCES(NS),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .src_addr (src_addr),
    .src_value(src_value),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_value (wb_value),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] v);
    src_addr[i*AW +: AW]  = a;
    src_value[i*DW +: DW] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    chk({tag, "_valid"}, 64'(wb_valid), 64'(v));
    chk({tag, "_addr"},  64'(wb_addr),  64'(a));
    chk({tag, "_value"}, 64'(wb_value), 64'(d));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_wb(tag, 1'b0, '0, '0);
    chk({tag, "_init"},  64'(init_done), 64'(0));
    chk({tag, "_ready"}, 64'(src_ready), 64'(0));
  endtask

  initial begin
    logic [NS-1:0] exp_ready;
    int g;

    rst       = 1'b1;
    src_valid = '1;
    src_addr  = '0;
    src_value = '0;
    set_src(0, 5'd10, 32'h0000_00A0);
    set_src(1, 5'd11, 32'h0000_00B1);
    set_src(2, 5'd12, 32'h0000_00C2);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Zero-fill sweep; producers request throughout but must be stalled.
    for (int i = 0; i < 32; i++) begin
      chk("sweep_ready", 64'(src_ready), 64'(0));
      step();
      chk_wb("sweep", 1'b1, AW'(i), '0);
      chk("sweep_init", 64'(init_done), 64'(i == 31));
    end
    src_valid = '0;
    step();
    chk_wb("post_sweep", 1'b0, 5'd31, '0);
    chk("post_sweep_init", 64'(init_done), 64'(1));

    // Single source 1; rr_ptr becomes 2.
    set_src(1, 5'd5, 32'hDEAD_BEEF);
    src_valid = 3'b010;
    #1;
    chk("single_ready", 64'(src_ready), 64'(3'b010));
    step();
    chk_wb("single", 1'b1, 5'd5, 32'hDEAD_BEEF);

    // rr_ptr=2 with 0 and 1 requesting: scan 2,0 -> grant 0, rr_ptr=1.
    set_src(0, 5'd3, 32'h0000_0033);
    set_src(1, 5'd4, 32'h0000_0044);
    src_valid = 3'b011;
    #1;
    chk("wrap_ready0", 64'(src_ready), 64'(3'b001));
    step();
    chk_wb("wrap_g0", 1'b1, 5'd3, 32'h0000_0033);
    // Idle cycle: nothing granted, outputs hold, rr_ptr stays 1.
    src_valid = 3'b000;
    #1;
    chk("idle_ready", 64'(src_ready), 64'(0));
    step();
    chk_wb("idle", 1'b0, 5'd3, 32'h0000_0033);
    // Both request again: held rr_ptr=1 means source 1 wins.
    src_valid = 3'b011;
    #1;
    chk("wrap_ready1", 64'(src_ready), 64'(3'b010));
    step();
    chk_wb("wrap_g1", 1'b1, 5'd4, 32'h0000_0044);

    // rr_ptr=2: source 2 alone brings rr_ptr back to 0.
    set_src(0, 5'd10, 32'h0000_00A0);
    set_src(1, 5'd11, 32'h0000_00B1);
    set_src(2, 5'd12, 32'h0000_00C2);
    src_valid = 3'b100;
    step();
    chk_wb("to_rr0", 1'b1, 5'd12, 32'h0000_00C2);

    // Full contention from rr_ptr=0: 0,1,2,0,1,2.
    src_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      g = i % 3;
      exp_ready = '0;
      exp_ready[g] = 1'b1;
      #1;
      chk("rr_ready", 64'(src_ready), 64'(exp_ready));
      step();
      chk_wb("rr", 1'b1, AW'(10 + g), DW'(32'hA0 + g * 32'h11));
    end

    // r0 request from source 0 with rr_ptr=0.
    set_src(0, 5'd0, 32'd7);
    src_valid = 3'b001;
    #1;
    chk("r0_ready", 64'(src_ready), 64'(3'b001));
    step();
`ifdef GECKO_WRITEBACK_R0_FILTER_EN
    chk_wb("r0", 1'b0, 5'd12, 32'h0000_00C2);
`else
    chk_wb("r0", 1'b1, 5'd0, 32'd7);
`endif
    // rr_ptr advanced to 1 in both builds.
    src_valid = 3'b011;
    #1;
    chk("r0_rr_ready", 64'(src_ready), 64'(3'b010));

    // Async reset in RUN with requests pending and a write just issued.
    src_valid = 3'b111;
    step();
    chk_wb("pre_rst", 1'b1, 5'd11, 32'h0000_00B1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_run");
    @(negedge clk);
    rst = 1'b0;
    src_valid = '0;

    // Sweep up to address 17, then reset again mid-sweep.
    for (int i = 0; i <= 17; i++) begin
      step();
      chk_wb("resweep", 1'b1, AW'(i), '0);
    end
    chk("resweep_init", 64'(init_done), 64'(0));
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_sweep");
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_wb("restart", 1'b1, 5'd0, '0);
    chk("restart_init", 64'(init_done), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
